// File: rtl/instr_prefetch_queue.sv
// Instruction register with a DEPTH-entry opcode/operand prefetch queue.
// Head opcode feeds the decoder; head operand drives the shared IB_BUS through a tri-state.
module instr_prefetch_queue #(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned ARG_W   = 4,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             MainClock,
  input  logic             ResetN,
  input  logic             ClearInstr,
  input  logic             LatchInstr,
  input  logic [OP_W-1:0]  Instr,
  input  logic [ARG_W-1:0] Data,
  input  logic             Advance,
  input  logic             EnableInstr,
  output logic [OP_W-1:0]  ToInstr,
  output tri   [ARG_W-1:0] IB_BUS,
  output logic             Full,
  output logic             Empty,
  output logic [CNT_W-1:0] Count,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int unsigned EntW = OP_W + ARG_W;

  logic [EntW-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic            push_ok, pop_ok;
  logic [EntW-1:0] head;
  logic [ARG_W-1:0] head_arg;

  assign Full  = (count_q == CNT_W'(DEPTH));
  assign Empty = (count_q == '0);

  // A pop frees the slot in the same edge, so a push into a full queue is legal alongside it.
  assign push_ok = LatchInstr && (!Full || Advance);
  assign pop_ok  = Advance && !Empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (ClearInstr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
      if (LatchInstr && Full && !Advance) ovf_d = 1'b1;
      if (Advance && Empty)               udf_d = 1'b1;
    end
  end

  always_ff @(posedge MainClock or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage needs no reset: it is only observed through rd_ptr while Count is non-zero.
  always_ff @(posedge MainClock) begin
    if (push_ok && !ClearInstr) mem_q[wr_ptr_q] <= {Instr, Data};
  end

  assign head      = mem_q[rd_ptr_q];
  assign ToInstr   = Empty ? '0 : head[EntW-1:ARG_W];
  assign head_arg  = Empty ? '0 : head[ARG_W-1:0];
  assign IB_BUS    = EnableInstr ? head_arg : {ARG_W{1'bz}};
  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign Underflow = udf_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios plus a randomized run against a
// queue-based reference model.
module tb_instr_prefetch_queue;

  localparam int OP_W  = 4;
  localparam int ARG_W = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             latch = 1'b0;
  logic             adv = 1'b0;
  logic             en = 1'b0;
  logic [OP_W-1:0]  instr = '0;
  logic [ARG_W-1:0] data = '0;
  logic [OP_W-1:0]  to_instr;
  tri1  [ARG_W-1:0] ib_bus;  // released bus reads all ones
  logic             full, empty, ovf, udf;
  logic [CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;

  // Reference model: entries as {opcode, operand}, oldest at index 0.
  logic [7:0] mq[$];
  bit         m_ovf, m_udf;

  instr_prefetch_queue #(.OP_W(OP_W), .ARG_W(ARG_W), .DEPTH(DEPTH)) dut (
    .MainClock  (clk),
    .ResetN     (rst_n),
    .ClearInstr (clr),
    .LatchInstr (latch),
    .Instr      (instr),
    .Data       (data),
    .Advance    (adv),
    .EnableInstr(en),
    .ToInstr    (to_instr),
    .IB_BUS     (ib_bus),
    .Full       (full),
    .Empty      (empty),
    .Count      (count),
    .Overflow   (ovf),
    .Underflow  (udf)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_head_op();
    return (mq.size() == 0) ? 4'h0 : mq[0][7:4];
  endfunction

  function automatic logic [3:0] m_head_arg();
    return (mq.size() == 0) ? 4'h0 : mq[0][3:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_udf = 0;
  endtask

  // One clock edge with the given inputs; the model sees the same inputs at the same edge.
  task automatic drive(input bit l, input logic [3:0] op, input logic [3:0] arg,
                       input bit a, input bit c);
    bit was_full, was_empty;
    latch = l; instr = op; data = arg; adv = a; clr = c;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (c) model_reset();
    else begin
      if (a && was_empty) m_udf = 1;
      if (l && was_full && !a) m_ovf = 1;
      if (a && !was_empty) void'(mq.pop_front());
      if (l && (!was_full || a)) mq.push_back({op, arg});
    end
    @(posedge clk);
    #1;
    latch = 0; adv = 0; clr = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if (count !== '0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (to_instr !== 4'h0) begin errors++; $display("FAIL rst_toinstr got=%h exp=0", to_instr); end
    checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL rst_flags got=%b exp=00", {ovf, udf}); end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) drive(1, 4'(i + 1), 4'(i + 10), 0, 0);
    checks++; if (count !== 3'(mq.size())) begin errors++; $display("FAIL mid_pre_count got=%0d exp=%0d", count, mq.size()); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got=%b exp=1", empty); end
    checks++; if (count !== '0) begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
    checks++; if (to_instr !== 4'h0) begin errors++; $display("FAIL mid_rst_toinstr got=%h exp=0", to_instr); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) drive(1, 4'(i + 1), 4'(i + 4'hA), 0, 0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++; if (to_instr !== 4'h1) begin errors++; $display("FAIL fill_head got=%h exp=1", to_instr); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0);
      checks++;
      if (to_instr !== ((i < 3) ? 4'(i + 2) : 4'h0)) begin
        errors++; $display("FAIL drain_head[%0d] got=%h exp=%h", i, to_instr, m_head_op());
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL drain_udf got=%b exp=0", udf); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) drive(1, 4'(i + 1), 4'(i + 4'hA), 0, 0);
    drive(1, 4'h5, 4'hE, 0, 0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    checks++; if (to_instr !== 4'h1) begin errors++; $display("FAIL ovf_head got=%h exp=1", to_instr); end
    drive(1, 4'h5, 4'hE, 1, 0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_pp_count got=%0d exp=4", count); end
    checks++; if (to_instr !== 4'h2) begin errors++; $display("FAIL ovf_pp_head got=%h exp=2", to_instr); end
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL ovf_pp_udf got=%b exp=0", udf); end
    // Only the accepted (5,E) may reach the head, and only after 2,3,4.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0);
      checks++;
      if (to_instr !== m_head_op()) begin
        errors++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, to_instr, m_head_op());
      end
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    drive(0, 0, 0, 0, 1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
  endtask

  task automatic test_wrap();
    logic [3:0] op, arg;
    for (int i = 0; i < 10; i++) begin
      op  = 4'($urandom_range(1, 15));
      arg = 4'($urandom);
      drive(1, op, arg, 0, 0);
      checks++;
      if (to_instr !== op || count !== 3'd1) begin
        errors++; $display("FAIL wrap_push[%0d] head=%h cnt=%0d exp head=%h cnt=1", i, to_instr, count, op);
      end
      drive(0, 0, 0, 1, 0);
      checks++;
      if (count !== 3'd0 || empty !== 1'b1) begin
        errors++; $display("FAIL wrap_pop[%0d] cnt=%0d empty=%b exp cnt=0 empty=1", i, count, empty);
      end
    end
  endtask

  task automatic test_empty_simul();
    drive(1, 4'h7, 4'h9, 1, 0);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL es_count got=%0d exp=1", count); end
    checks++; if (to_instr !== 4'h7) begin errors++; $display("FAIL es_head got=%h exp=7", to_instr); end
    checks++; if (udf !== 1'b1) begin errors++; $display("FAIL es_udf got=%b exp=1", udf); end
    drive(0, 0, 0, 0, 1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL es_clr_empty got=%b exp=1", empty); end
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL es_clr_udf got=%b exp=0", udf); end
  endtask

  task automatic test_bus();
    drive(1, 4'h3, 4'h9, 0, 0);
    en = 1'b1; #1;
    checks++; if (ib_bus !== 4'h9) begin errors++; $display("FAIL bus_drive got=%h exp=9", ib_bus); end
    en = 1'b0; #1;
    checks++; if (ib_bus !== 4'hF) begin errors++; $display("FAIL bus_release got=%h exp=F(pulled)", ib_bus); end
    drive(0, 0, 0, 1, 0);
    en = 1'b1; #1;
    checks++; if (ib_bus !== 4'h0) begin errors++; $display("FAIL bus_empty got=%h exp=0", ib_bus); end
    en = 1'b0;
  endtask

  task automatic test_random();
    bit l, a, c;
    for (int i = 0; i < 400; i++) begin
      l  = ($urandom_range(0, 99) < 60);
      a  = ($urandom_range(0, 99) < 45);
      c  = ($urandom_range(0, 99) < 3);
      en = 1'($urandom);
      drive(l, 4'($urandom), 4'($urandom), a, c);
      checks++;
      if (count !== 3'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
        errors++;
        $display("FAIL rnd_status[%0d] cnt=%0d full=%b empty=%b exp cnt=%0d", i, count, full, empty, mq.size());
      end
      checks++;
      if (to_instr !== m_head_op()) begin
        errors++; $display("FAIL rnd_head[%0d] got=%h exp=%h", i, to_instr, m_head_op());
      end
      checks++;
      if (ovf !== m_ovf || udf !== m_udf) begin
        errors++; $display("FAIL rnd_flags[%0d] ovf=%b udf=%b exp ovf=%b udf=%b", i, ovf, udf, m_ovf, m_udf);
      end
      if (en) begin
        checks++;
        if (ib_bus !== m_head_arg()) begin
          errors++; $display("FAIL rnd_bus[%0d] got=%h exp=%h", i, ib_bus, m_head_arg());
        end
      end
    end
    en = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_wrap();
    test_empty_simul();
    test_bus();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
